// File: rtl/mul_result_led_sequencer.sv
// Shows a captured 32-bit MUL product on the 8-bit LED bank one byte at a time, LSB first.
// Optional macro LED_SEQ_BLANK_GAP_EN inserts a blanked gap between consecutive bytes.
module mul_result_led_sequencer #(
  parameter int unsigned DWELL_CYCLES = 25000000,
  parameter int unsigned CNT_WIDTH    = 25
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iValid,
  input  logic [31:0] iData,
  output logic        oReady,
  output logic [7:0]  oLed,
  output logic [1:0]  oByteIndex,
  output logic        oBusy,
  output logic        oDone
);

  localparam logic [CNT_WIDTH-1:0] LAST_DWELL = CNT_WIDTH'(DWELL_CYCLES - 1);

`ifdef LED_SEQ_BLANK_GAP_EN
  localparam int unsigned GAP = ((DWELL_CYCLES / 4) > 0) ? (DWELL_CYCLES / 4) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_GAP = CNT_WIDTH'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1
  } state_e;
`endif

  state_e               state_q, state_d;
  logic [31:0]          word_q, word_d;
  logic [7:0]           led_q, led_d;
  logic [1:0]           idx_q, idx_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [1:0]           nxt_idx;
  logic [7:0]           nxt_byte;

  // Next-state and next-output decode
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    led_d    = led_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    nxt_idx  = idx_q + 2'd1;
    nxt_byte = word_q[{nxt_idx, 3'b000} +: 8];

    case (state_q)
      IDLE: begin
        if (iValid) begin
          word_d  = iData;
          led_d   = iData[7:0];
          idx_d   = 2'd0;
          cnt_d   = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == LAST_DWELL) begin
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            // Byte 3 stays lit after the sequence ends
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef LED_SEQ_BLANK_GAP_EN
            state_d = BLANK;
            led_d   = 8'h00;
`else
            idx_d   = nxt_idx;
            led_d   = nxt_byte;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
`ifdef LED_SEQ_BLANK_GAP_EN
      BLANK: begin
        if (cnt_q == LAST_GAP) begin
          cnt_d   = '0;
          idx_d   = nxt_idx;
          led_d   = nxt_byte;
          state_d = SHOW;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      led_q   <= 8'h00;
      idx_q   <= 2'd0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      led_q   <= led_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oReady     = (state_q == IDLE);
  assign oBusy      = (state_q != IDLE);
  assign oLed       = led_q;
  assign oByteIndex = idx_q;
  assign oDone      = done_q;

endmodule

// File: doc/mul_result_led_sequencer.md
Name: mul_result_led_sequencer

Overview:
- Downstream consumer of the MiniAlu 32-bit MUL product, which is wider than the 8-bit LED bank.
- Captures one 32-bit word on a valid/ready handshake, then shows it on the 8 board LEDs one byte at a time, LSB byte first.
- Each byte is held for a programmable dwell time.
- Sits between the ALU result path and the Spartan-3E LED pins, in place of the single-byte LED register.

Parameters:
DWELL_CYCLES, 25000000, clock cycles each byte is displayed; legal range 1 to 2^CNT_WIDTH-1 (0.5 s at 50 MHz).
CNT_WIDTH, 25, width of the dwell counter.

Ports:
Clock  input  1  system clock, all state updates on rising edge.
Reset  input  1  asynchronous, active-high reset.
iValid  input  1  iData holds a word to display.
iData  input  32  word to display; byte 0 = iData[7:0].
oReady  output  1  block can accept a word this cycle.
oLed  output  8  registered LED drive.
oByteIndex  output  2  index of the byte currently on oLed.
oBusy  output  1  high while a word is being sequenced.
oDone  output  1  one-cycle pulse after the last byte's dwell ends.

Behaviour:
- Interface: one clock, Clock. Reset is asynchronous and active-high, named Reset. Polarity and synchronicity are fixed.
- Reset, asserted at any time including mid-sequence: state=IDLE, oLed=8'h00, oByteIndex=0, oDone=0, dwell counter=0, captured word=0. oReady=1 and oBusy=0 once Reset deasserts.
- States: IDLE, SHOW, plus BLANK only when the optional feature is compiled in.
- oReady = (state==IDLE). oBusy = (state!=IDLE). Both are decoded combinationally from the state register.
- Handshake: a transfer occurs on a rising edge where iValid && oReady. At that edge:
  - capture iData;
  - oLed <= iData[7:0], oByteIndex <= 0, counter <= 0;
  - state <= SHOW.
- iValid while oReady=0 is ignored. The word is not queued and iData is not sampled.
- SHOW: the counter increments every cycle. When counter==DWELL_CYCLES-1:
  - oByteIndex<3: oByteIndex <= oByteIndex+1, oLed <= the next captured byte, counter <= 0.
  - oByteIndex==3: state <= IDLE, oDone <= 1 for exactly one cycle, oLed keeps byte 3, oByteIndex keeps 3, counter <= 0.
- Each byte is on oLed for exactly DWELL_CYCLES cycles. Transfer edge to oDone-high edge = 4*DWELL_CYCLES cycles.
- Back-to-back: oReady is already 1 in the oDone cycle. A new word presented then is captured on the next edge, with no extra idle cycle.
- DWELL_CYCLES=1 is the boundary case: each byte is shown for a single cycle and the counter never leaves 0.
- oLed, oByteIndex and oDone are all flop outputs with no combinational path from inputs. Latency from transfer edge to byte 0 on oLed is 0 cycles; it is visible directly after that edge.

Optional Feature:
Macro LED_SEQ_BLANK_GAP_EN.
- Defined:
  - After the dwell of bytes 0, 1 and 2, the block enters BLANK instead of advancing directly.
  - In BLANK, oLed=8'h00 for GAP = max(1, DWELL_CYCLES/4) cycles (integer division).
  - oByteIndex holds the byte just shown.
  - At the end of BLANK: load the next byte, increment oByteIndex, counter <= 0, state <= SHOW.
  - There is no gap after byte 3.
  - Total sequence length = 4*DWELL_CYCLES + 3*GAP.
- Undefined: the BLANK state and its logic are absent, and behaviour is exactly as in Behaviour above.

Test Plan:
1. DWELL_CYCLES=4, iValid=1 with iData=32'hA1B2C3D4 for one cycle -> oLed shows D4,C3,B2,A1 for 4 cycles each; oByteIndex steps 0..3; oDone is high for 1 cycle 16 cycles after the transfer edge; oLed stays A1 afterwards.
2. iValid held high with iData=32'h11223344 throughout a sequence that started with 32'hDEADBEEF -> EF,BE,AD,DE shown; the second word is captured on the edge after oDone and then shows 44,33,22,11 with no idle gap.
3. Reset pulsed asynchronously, between clock edges, while byte 2 is displayed -> oLed=00, oByteIndex=0, oBusy=0 immediately; oReady=1 after release; no oDone.
4. DWELL_CYCLES=1, word 32'h0F0E0D0C -> 0C,0D,0E,0F on consecutive cycles; oDone 4 cycles after the transfer.
5. LED_SEQ_BLANK_GAP_EN defined, DWELL_CYCLES=8, word 32'h04030201 -> sequence 01×8, 00×2, 02×8, 00×2, 03×8, 00×2, 04×8; oDone at cycle 38.
6. iValid pulsed mid-sequence with 32'hFFFFFFFF -> ignored; the original bytes complete unchanged and oReady stays 0 until the oDone cycle.
